mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single unified 16-bit memory port between two requesters: instruction fetch and data LD/ST/STU.
- The memory has a fixed, multi-cycle read latency. The block sequences each access (issue, wait, complete) and drives the pipeline stall signals.
- It sits between the fetch/memory stages and the memory macro, and consumes the MemRead/MemWrite/halt decisions made by decode.

Parameters:
- MEM_LAT, 4: cycles from mem_en to read data valid at mem_rdata. Legal range 1..15; the wait counter is 4 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- halt  in  1  HALT retired; blocks new fetch grants
- if_req  in  1  fetch request, level; held until if_done
- if_addr  in  16  fetch address (PC)
- if_rdata  out  16  fetched instruction, registered
- if_done  out  1  one-cycle completion pulse for fetch
- stall_if  out  1  if_req & ~if_done
- dm_rd  in  1  data read request (MemRead), level
- dm_wr  in  1  data write request (MemWrite), level
- dm_addr  in  16  data address (ALU result)
- dm_wdata  in  16  store data
- dm_rdata  out  16  load data, registered
- dm_done  out  1  one-cycle completion pulse for data
- stall_dm  out  1  (dm_rd|dm_wr) & ~dm_done
- mem_en  out  1  one-cycle access strobe to memory
- mem_wr  out  1  write qualifier, valid with mem_en
- mem_addr  out  16  address, valid with mem_en
- mem_wdata  out  16  write data, valid with mem_en
- mem_rdata  in  16  memory read data, valid MEM_LAT cycles after mem_en
- err  out  1  sticky protocol error

Behaviour:
- Reset: every output is 0, including if_rdata, dm_rdata and err. State is IDLE, the counter is 0, the grant is none and the round-robin pointer selects data.
- Reset wins over all other activity. An in-flight access is abandoned: no done pulse, no rdata update.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: grant is evaluated each cycle.
  - Data is granted if dm_rd|dm_wr.
  - Otherwise fetch is granted if if_req & ~halt.
  - On a grant: latch port, address, write flag and wdata, then go to ISSUE. No request: stay in IDLE.
- ISSUE: mem_en=1 for exactly this cycle, with mem_wr/mem_addr/mem_wdata from the latch. The counter loads MEM_LAT-1.
  - If MEM_LAT==1, go to DONE; else go to WAIT.
- WAIT: the counter decrements each cycle. When the counter reaches 1, go to DONE.
- Read capture: at the edge ending cycle (issue + MEM_LAT - 1), mem_rdata is captured into the granted port's rdata register. A write never changes either rdata register.
- DONE: the granted port's done pulses for one cycle, then the state returns to IDLE.
- Latency: request sampled in IDLE cycle t → mem_en at t+1 → done at t+1+MEM_LAT. Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Requesters hold their request and operands stable until done. A new request is sampled only in IDLE, so a stale level request is never re-granted in the DONE cycle.
- dm_rd & dm_wr both high when sampled in IDLE: treated as a write, and err is set. err stays set until rst.
- halt: an in-flight fetch completes normally. After that, fetch is never granted while halt=1. Data requests are still served.
- Outputs mem_wr/mem_addr/mem_wdata are 0 whenever mem_en=0.

Optional Feature:
- MEM_ARB_FAIR_EN defined: round-robin arbitration. When both ports request in IDLE, the port not granted last wins. The pointer updates on each grant and resets to data.
- Undefined: fixed data-over-fetch priority, no pointer register.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, DONE)
  - port enum (NONE, FETCH, DATA)
  - constant for the 4-bit counter width
  - parameter legality bound MEM_LAT_MAX=15
- One sub-module, mem_arb_grant: combinational pick of FETCH/DATA/NONE from the requests, halt and the optional round-robin pointer. It is instantiated once.

Test Plan:
1. Reset: rst=1 for 2 cycles with requests active → all outputs 0; the first mem_en appears 2 cycles after rst falls.
2. Fetch, MEM_LAT=4, if_addr=0x0010, memory returns 0x1234 → mem_en=1 with mem_wr=0 and addr 0x0010 at cycle 1; if_done=1 and if_rdata=0x1234 at cycle 5; stall_if=1 in cycles 0–4.
3. if_req and dm_rd both high at cycle 0 (fixed priority) → data done at cycle 5; fetch mem_en at cycle 7; if_done at cycle 11. With MEM_ARB_FAIR_EN and a prior data grant, fetch wins first instead.
4. Store dm_wr, addr 0x0100, wdata 0xBEEF → at cycle 1, mem_en=mem_wr=1, mem_wdata=0xBEEF; dm_done at cycle 5; dm_rdata unchanged.
5. halt=1 while a fetch is in WAIT → that fetch completes. A subsequent held if_req gets no mem_en for 20 cycles; a dm_rd in that window is served with MEM_LAT+1 latency.
6. Two scenarios on one bench:
   - rst pulse at cycle 3 of an access → no done pulse, outputs 0 next cycle.
   - dm_rd & dm_wr both high → write performed, err=1 and held until rst.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Round-robin support elsewhere is selected with the MEM_ARB_FAIR_EN macro.
package mem_arb_pkg;

  localparam int CNT_W       = 4;
  localparam int MEM_LAT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    FETCH,
    DATA
  } port_t;

  // The requester that should win the next tie after port p was served.
  function automatic port_t other_port(input port_t p);
    return (p == DATA) ? FETCH : DATA;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant pick between fetch and data requesters.
// MEM_ARB_FAIR_EN adds a round-robin pointer input; otherwise data always wins.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic  if_req,
  input  logic  dm_rd,
  input  logic  dm_wr,
  input  logic  halt,
`ifdef MEM_ARB_FAIR_EN
  input  port_t rr_ptr,
`endif
  output port_t grant
);

  logic dm_req;
  logic if_ok;

  always_comb begin
    dm_req = dm_rd | dm_wr;
    if_ok  = if_req & ~halt;
    grant  = NONE;
`ifdef MEM_ARB_FAIR_EN
    if (dm_req && if_ok) begin
      grant = (rr_ptr == FETCH) ? FETCH : DATA;
    end else if (dm_req) begin
      grant = DATA;
    end else if (if_ok) begin
      grant = FETCH;
    end
`else
    if (dm_req) begin
      grant = DATA;
    end else if (if_ok) begin
      grant = FETCH;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 16-bit memory port between instruction fetch and data accesses,
// sequencing issue/wait/done around a fixed read latency. Optional: MEM_ARB_FAIR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        stall_if,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        stall_dm,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        err
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
      $error("mem_arbiter: MEM_LAT outside 1..MEM_LAT_MAX");
    end
  endgenerate

  state_t            state_q;
  state_t            state_d;
  port_t             port_q;
  port_t             grant;
  logic              wr_q;
  logic [15:0]       addr_q;
  logic [15:0]       wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              capture;

`ifdef MEM_ARB_FAIR_EN
  port_t rr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= DATA;
    end else if (state_q == IDLE && grant != NONE) begin
      rr_q <= other_port(grant);
    end
  end

  mem_arb_grant u_grant (
    .if_req (if_req),
    .dm_rd  (dm_rd),
    .dm_wr  (dm_wr),
    .halt   (halt),
    .rr_ptr (rr_q),
    .grant  (grant)
  );
`else
  mem_arb_grant u_grant (
    .if_req (if_req),
    .dm_rd  (dm_rd),
    .dm_wr  (dm_wr),
    .halt   (halt),
    .grant  (grant)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant != NONE) state_d = ISSUE;
      ISSUE:   state_d = (MEM_LAT == 1) ? DONE : WAIT;
      WAIT:    if (cnt_q == CNT_ONE) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data is taken on the edge that ends the last latency cycle.
  assign capture = ~wr_q &&
                   (((state_q == ISSUE) && (MEM_LAT == 1)) ||
                    ((state_q == WAIT) && (cnt_q == CNT_ONE)));

  always_ff @(posedge clk) begin
    if (rst) begin
      port_q   <= NONE;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      err      <= 1'b0;
    end else begin
      if (state_q == IDLE && grant != NONE) begin
        port_q  <= grant;
        wr_q    <= (grant == DATA) && dm_wr;
        addr_q  <= (grant == DATA) ? dm_addr : if_addr;
        wdata_q <= (grant == DATA) ? dm_wdata : 16'h0000;
      end
      if (state_q == IDLE && dm_rd && dm_wr) begin
        err <= 1'b1;
      end
      if (state_q == ISSUE) begin
        cnt_q <= LAT_LOAD;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - CNT_ONE;
      end
      if (capture && port_q == FETCH) begin
        if_rdata <= mem_rdata;
      end
      if (capture && port_q == DATA) begin
        dm_rdata <= mem_rdata;
      end
    end
  end

  // Stalls are masked during reset so every output reads 0 while rst is high.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_done   = 1'b0;
    dm_done   = 1'b0;
    unique case (state_q)
      ISSUE: begin
        mem_en    = 1'b1;
        mem_wr    = wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      DONE: begin
        if_done = (port_q == FETCH);
        dm_done = (port_q == DATA);
      end
      default: ;
    endcase
    stall_if = if_req & ~if_done & ~rst;
    stall_dm = (dm_rd | dm_wr) & ~dm_done & ~rst;
  end

endmodule
